// File: rtl/arb_grant_lock.sv
// Grant-locking stage around a combinational priority arbiter: registers the
// arbiter's one-hot grant and holds it for the owner's burst (max MAX_BURST cycles).
module arb_grant_lock #(
  parameter  int NUM_PORTS = 17,
  parameter  int MAX_BURST = 8,
  localparam int IDX_W     = $clog2(NUM_PORTS),
  localparam int CNT_W     = $clog2(MAX_BURST) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] req_i,
  output logic [NUM_PORTS-1:0] arb_req_o,
  input  logic [NUM_PORTS-1:0] arb_gnt_i,
  output logic [NUM_PORTS-1:0] gnt_o,
  output logic                 gnt_valid_o,
  output logic [IDX_W-1:0]     gnt_idx_o,
  output logic [CNT_W-1:0]     burst_cnt_o,
  output logic                 protocol_err_o
);

  typedef enum logic {IDLE, OWN} state_t;

  state_t               state_q, state_d;
  logic [NUM_PORTS-1:0] gnt_q, gnt_d;
  logic                 valid_q;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_PORTS-1:0] mask_q, mask_d;
  logic                 err_q, err_d;

  logic [NUM_PORTS-1:0] masked;
  logic [NUM_PORTS-1:0] req_fwd;
  logic                 gnt_multi;
  logic                 gnt_stray;
  logic [IDX_W-1:0]     gnt_bin;

  always_comb begin
    gnt_bin = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (arb_gnt_i[i]) gnt_bin = IDX_W'(i);
    end
  end

  // The arbiter request depends only on state, req_i and mask_q, never on
  // arb_gnt_i, so the loop through the external arbiter stays acyclic.
  always_comb begin
    masked  = req_i & ~mask_q;
    req_fwd = '0;
    if (state_q == IDLE) req_fwd = (|masked) ? masked : req_i;
  end

  assign arb_req_o = req_fwd;
  assign gnt_multi = |(arb_gnt_i & (arb_gnt_i - NUM_PORTS'(1)));
  assign gnt_stray = |(arb_gnt_i & ~req_fwd);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if ((|arb_gnt_i) && !gnt_multi && !gnt_stray) begin
          state_d = OWN;
          gnt_d   = arb_gnt_i;
          idx_d   = gnt_bin;
          cnt_d   = '0;
          mask_d  = '0;
        end else begin
          if (gnt_multi || gnt_stray) err_d = 1'b1;
          if (|req_i) mask_d = '0;
        end
      end
      OWN: begin
        // Release wins over expiry, so a simultaneous drop leaves no mask.
        if (!(|(req_i & gnt_q))) begin
          state_d = IDLE;
          gnt_d   = '0;
          idx_d   = '0;
          cnt_d   = '0;
          mask_d  = '0;
        end else if (cnt_q == CNT_W'(MAX_BURST - 1)) begin
          state_d = IDLE;
          gnt_d   = '0;
          idx_d   = '0;
          cnt_d   = '0;
          mask_d  = gnt_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      mask_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      valid_q <= |gnt_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      err_q   <= err_d;
    end
  end

  assign gnt_o          = gnt_q;
  assign gnt_valid_o    = valid_q;
  assign gnt_idx_o      = idx_q;
  assign burst_cnt_o    = cnt_q;
  assign protocol_err_o = err_q;

endmodule

// File: doc/arb_grant_lock.md
Name: arb_grant_lock

Overview:
- Sequential grant-locking stage that wraps the team's combinational NUM_PORTS priority arbiter.
- Forwards client requests to the arbiter and captures the arbiter's one-hot grant into a registered, held grant.
- Keeps that grant for the owner's whole burst, up to MAX_BURST cycles, then forces re-arbitration.
- Masks a preempted owner for one arbitration round so lower-priority clients make progress.

Parameters:
- NUM_PORTS, 17, number of requesting clients; must be >= 2.
- MAX_BURST, 8, maximum consecutive cycles one owner holds the grant; must be >= 1.
- Derived localparams: IDX_W = $clog2(NUM_PORTS); CNT_W = $clog2(MAX_BURST) + 1.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_i  input  NUM_PORTS  raw client requests, level-held while the client wants the resource.
- arb_req_o  output  NUM_PORTS  combinational request vector to the arbiter.
- arb_gnt_i  input  NUM_PORTS  combinational one-hot (or zero) grant from the arbiter.
- gnt_o  output  NUM_PORTS  registered, locked one-hot grant to clients.
- gnt_valid_o  output  1  registered; equals |gnt_o.
- gnt_idx_o  output  IDX_W  registered binary index of gnt_o; 0 when gnt_valid_o=0.
- burst_cnt_o  output  CNT_W  cycles the current owner has held the grant, 0-based.
- protocol_err_o  output  1  sticky arbiter-protocol error flag.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset, sampled at an edge, produces on the next cycle:
  - state=IDLE; gnt_o, gnt_valid_o, gnt_idx_o, burst_cnt_o and block_mask all 0; protocol_err_o=0.
  - Reset mid-burst drops the grant on the next cycle, with no completion semantics.
- States: IDLE, OWN.
- IDLE:
  - masked = req_i & ~block_mask.
  - arb_req_o = masked if masked != 0, else req_i.
  - Valid grant: arb_gnt_i is one-hot and arb_gnt_i & arb_req_o != 0. At the next edge:
    - gnt_o <= arb_gnt_i; gnt_idx_o <= index; burst_cnt_o <= 0; block_mask <= 0; state <= OWN.
  - Latency: request in IDLE at cycle t gives gnt_o at cycle t+1.
  - arb_gnt_i == 0: stay in IDLE; block_mask is retained only if req_i was 0.
- OWN:
  - arb_req_o = 0.
  - gnt_o and gnt_idx_o are held; arb_gnt_i is ignored.
  - Each cycle, in priority order:
    - req_i[owner]==0 (voluntary release): next cycle gnt_o=0, state=IDLE, block_mask=0, burst_cnt_o=0.
    - else burst_cnt_o == MAX_BURST-1 (preempt): next cycle gnt_o=0, state=IDLE, block_mask=one-hot(owner), burst_cnt_o=0.
    - else burst_cnt_o <= burst_cnt_o + 1.
  - Maximum hold is exactly MAX_BURST cycles.
  - There is always at least one cycle with gnt_o=0 between consecutive grants; back-to-back grants are not allowed.
- MAX_BURST=1: every grant lasts one cycle and preempts if the request is still high.
- Simultaneous release and count expiry: treated as a release, so block_mask=0.
- Protocol errors, checked in IDLE only:
  - arb_gnt_i has more than one bit set, or it grants a bit not set in arb_req_o.
  - Effect: protocol_err_o <= 1 (sticky until reset), no capture, state stays IDLE.
- Only reset clears protocol_err_o.
- Outputs other than arb_req_o are registered.
- arb_req_o is combinational from state, req_i and block_mask, with no path from arb_gnt_i. This keeps the arbiter loop acyclic.

Test Plan:
Bench pairs the block with the team's 17-port priority arbiter (lowest index wins); MAX_BURST=8.
- Reset, then req_i=0 -> gnt_o=0, gnt_valid_o=0, gnt_idx_o=0, arb_req_o=0, protocol_err_o=0.
- req_i bit3 raised at cycle t and held 3 cycles, then dropped -> gnt_o=0x00008 from t+1; burst_cnt_o 0,1,2; gnt_o=0 the cycle after req drops.
- req_i bits 2 and 5 held continuously -> port 2 granted 8 cycles (burst_cnt_o 0..7); 1 idle cycle; port 5 granted 8 cycles (mask on 2); idle; port 2 again.
- Port 5 granted; at burst_cnt_o=2 raise bit 0 -> gnt_o stays 0x00020 until port 5 releases or completes 8 cycles; no switch mid-burst.
- Bench forces arb_gnt_i=0x00003 in IDLE, then separately arb_gnt_i=0x10000 with req_i bit16=0 -> protocol_err_o=1 and stays set; gnt_o stays 0; reset clears the flag.
- Reset asserted while port 7 owns the grant with burst_cnt_o=4 -> next cycle gnt_o=0, burst_cnt_o=0, block_mask=0; after reset, port 7 is re-granted normally.
